// File: rtl/hilotof_status_ctrl.sv
// Board-level housekeeping for HiLoTOF tops: power-on reset stretcher,
// DUT reset combiner with a transaction watchdog, LED pulse stretchers
// and a heartbeat blinker.
module hilotof_status_ctrl #(
  parameter int RESET_CYCLES   = 63,
  parameter int N_CH           = 8,
  parameter int STRETCH_BITS   = 20,
  parameter int HB_BITS        = 26,
  parameter int WDT_CYCLES     = 1000000,
  parameter int WDT_RST_CYCLES = 16,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  output logic            sys_reset,
  input  logic            dut_reset_req,
  output logic            dut_reset,
  input  logic            txn_start,
  input  logic            txn_done,
  input  logic [N_CH-1:0] status,
  output logic            wdt_timeout,
  output logic [7:0]      wdt_count,
  output logic            heartbeat,
  output logic [N_CH-1:0] led
);

  localparam int RC_W = $clog2(RESET_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RESET_CYCLES);

  localparam bit WDT_EN = (WDT_CYCLES > 0);
  localparam int WT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WT_W-1:0] WT_LAST = WT_W'((WDT_CYCLES > 0) ? WDT_CYCLES - 1 : 0);
  localparam int PC_W = (WDT_RST_CYCLES > 1) ? $clog2(WDT_RST_CYCLES) : 1;
  localparam logic [PC_W-1:0] PC_LOAD = PC_W'(WDT_RST_CYCLES - 1);

  localparam logic [N_CH-1:0] LED_OFF = {N_CH{LED_ACTIVE_LOW}};

  typedef enum logic [1:0] {WD_IDLE, WD_BUSY, WD_FIRE} wd_state_t;

  // Timeout counter increments but sticks at its ceiling.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [RC_W-1:0] rst_cnt;
  logic [RC_W-1:0] rst_cnt_nxt;

  wd_state_t       wd_state, wd_state_nxt;
  logic [WT_W-1:0] wd_timer, wd_timer_nxt;
  logic [PC_W-1:0] wd_pulse, wd_pulse_nxt;
  logic            wd_timeout_nxt;
  logic [7:0]      wd_count_nxt;
  logic            wdt_fire;

  logic [STRETCH_BITS-1:0] str_cnt [N_CH];
  logic [N_CH-1:0]         lit;
  logic [HB_BITS-1:0]      hb_cnt;

  assign rst_cnt_nxt = (rst_cnt != RC_LAST) ? rst_cnt + 1'b1 : rst_cnt;

  // Power-on reset counter; sys_reset is registered from the next count so it drops glitch-free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rst_cnt   <= '0;
      sys_reset <= 1'b1;
    end else begin
      rst_cnt   <= rst_cnt_nxt;
      sys_reset <= (rst_cnt_nxt != RC_LAST);
    end
  end

  // Watchdog state, timer, pulse width and sticky statistics.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_state    <= WD_IDLE;
      wd_timer    <= '0;
      wd_pulse    <= '0;
      wdt_timeout <= 1'b0;
      wdt_count   <= 8'd0;
    end else begin
      wd_state    <= wd_state_nxt;
      wd_timer    <= wd_timer_nxt;
      wd_pulse    <= wd_pulse_nxt;
      wdt_timeout <= wd_timeout_nxt;
      wdt_count   <= wd_count_nxt;
    end
  end

  // Watchdog next-state: a completed transaction beats a timeout in the same cycle.
  always_comb begin
    wd_state_nxt   = wd_state;
    wd_timer_nxt   = wd_timer;
    wd_pulse_nxt   = wd_pulse;
    wd_timeout_nxt = wdt_timeout;
    wd_count_nxt   = wdt_count;
    if (!WDT_EN || sys_reset || dut_reset_req) begin
      wd_state_nxt = WD_IDLE;
    end else begin
      case (wd_state)
        WD_IDLE: begin
          if (txn_start) begin
            wd_state_nxt = WD_BUSY;
            wd_timer_nxt = '0;
          end
        end
        WD_BUSY: begin
          if (txn_done) begin
            if (txn_start) wd_timer_nxt = '0;
            else           wd_state_nxt = WD_IDLE;
          end else if (wd_timer == WT_LAST) begin
            wd_state_nxt   = WD_FIRE;
            wd_pulse_nxt   = PC_LOAD;
            wd_timeout_nxt = 1'b1;
            wd_count_nxt   = sat_inc8(wdt_count);
          end else begin
            wd_timer_nxt = wd_timer + 1'b1;
          end
        end
        WD_FIRE: begin
          if (wd_pulse == '0) wd_state_nxt = WD_IDLE;
          else                wd_pulse_nxt = wd_pulse - 1'b1;
        end
        default: wd_state_nxt = WD_IDLE;
      endcase
    end
  end

  assign wdt_fire  = (wd_state == WD_FIRE);
  assign dut_reset = sys_reset | dut_reset_req | wdt_fire;

  // Per-channel stretch counters: reload on status, then count down to zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) str_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (status[i])            str_cnt[i] <= '1;
        else if (|str_cnt[i])     str_cnt[i] <= str_cnt[i] - 1'b1;
      end
    end
  end

  // A channel is lit while its raw bit is high or its stretch is still running.
  always_comb begin
    lit = '0;
    for (int i = 0; i < N_CH; i++) lit[i] = status[i] | (|str_cnt[i]);
  end

  // Register LED drive with board polarity applied.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) led <= LED_OFF;
    else       led <= lit ^ LED_OFF;
  end

  // Free-running heartbeat counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) hb_cnt <= '0;
    else       hb_cnt <= hb_cnt + 1'b1;
  end

  assign heartbeat = hb_cnt[HB_BITS-1];

endmodule

// File: tb/tb_hilotof_status_ctrl.sv
// Scoreboard bench for hilotof_status_ctrl: the stimulus pushes the
// hand-derived expected outputs for every cycle, the monitor pops and
// compares on the falling edge.
module tb_hilotof_status_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       dut_reset_req = 1'b0;
  logic       txn_start = 1'b0;
  logic       txn_done = 1'b0;
  logic [7:0] status = 8'h00;

  logic       sys_reset, dut_reset, wdt_timeout, heartbeat;
  logic [7:0] wdt_count, led;
  logic       nw_sys_reset, nw_dut_reset, nw_wdt_timeout, nw_heartbeat;
  logic [7:0] nw_wdt_count, nw_led;

  always #5 clock = ~clock;

  hilotof_status_ctrl #(
    .RESET_CYCLES(4), .N_CH(8), .STRETCH_BITS(3), .HB_BITS(3),
    .WDT_CYCLES(10), .WDT_RST_CYCLES(3), .LED_ACTIVE_LOW(1'b1)
  ) u_dut (
    .clock(clock), .reset(reset), .sys_reset(sys_reset),
    .dut_reset_req(dut_reset_req), .dut_reset(dut_reset),
    .txn_start(txn_start), .txn_done(txn_done), .status(status),
    .wdt_timeout(wdt_timeout), .wdt_count(wdt_count),
    .heartbeat(heartbeat), .led(led)
  );

  hilotof_status_ctrl #(
    .RESET_CYCLES(4), .N_CH(8), .STRETCH_BITS(3), .HB_BITS(3),
    .WDT_CYCLES(0), .WDT_RST_CYCLES(3), .LED_ACTIVE_LOW(1'b1)
  ) u_nowdt (
    .clock(clock), .reset(reset), .sys_reset(nw_sys_reset),
    .dut_reset_req(dut_reset_req), .dut_reset(nw_dut_reset),
    .txn_start(txn_start), .txn_done(txn_done), .status(status),
    .wdt_timeout(nw_wdt_timeout), .wdt_count(nw_wdt_count),
    .heartbeat(nw_heartbeat), .led(nw_led)
  );

  typedef struct {
    logic       sr;
    logic       dr;
    logic       to;
    logic       hb;
    logic [7:0] cnt;
    logic [7:0] led;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       exp_fire = 1'b0;
  logic       exp_to = 1'b0;
  logic [7:0] exp_cnt = 8'd0;
  logic [7:0] exp_led = 8'hFF;
  string      phase = "reset";

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s/%s t=%0t got %0h expected %0h", phase, nm, $time, act, expv);
    end
  endtask

  // Advance past one rising edge, drive inputs for the next edge, queue expectations.
  task automatic tick(input logic s, input logic d, input logic r, input logic x);
    exp_t e;
    @(posedge clock);
    if (reset) cyc = 0;
    else       cyc++;
    #1;
    txn_start = s;
    txn_done = d;
    dut_reset_req = r;
    reset = x;
    e.sr  = x || (cyc < 4);
    e.hb  = x ? 1'b0 : cyc[2];
    e.dr  = e.sr | r | exp_fire;
    e.to  = exp_to;
    e.cnt = exp_cnt;
    e.led = exp_led;
    q.push_back(e);
  endtask

  task automatic run(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0, reset);
  endtask

  // Monitor: one expectation per falling edge, plus the watchdog-disabled instance.
  always @(negedge clock) begin
    exp_t me;
    if (q.size() > 0) begin
      me = q.pop_front();
      cmp("sys_reset", 8'(sys_reset), 8'(me.sr));
      cmp("dut_reset", 8'(dut_reset), 8'(me.dr));
      cmp("wdt_timeout", 8'(wdt_timeout), 8'(me.to));
      cmp("wdt_count", wdt_count, me.cnt);
      cmp("heartbeat", 8'(heartbeat), 8'(me.hb));
      cmp("led", led, me.led);
      cmp("nowdt_dut_reset", 8'(nw_dut_reset), 8'(nw_sys_reset | dut_reset_req));
      cmp("nowdt_timeout", 8'(nw_wdt_timeout), 8'd0);
    end
  end

  initial begin
    // Reset, release, async re-assert mid-count, full restart.
    phase = "reset";
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    run(2);
    phase = "reset_midcount";
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    run(8);

    phase = "wdt_fire";
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    run(10);
    exp_fire = 1'b1; exp_to = 1'b1; exp_cnt = 8'd1;
    run(3);
    exp_fire = 1'b0;
    run(2);

    phase = "wdt_done9";
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    run(8);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    run(6);

    phase = "wdt_b2b";
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    run(7);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    run(10);
    exp_fire = 1'b1; exp_cnt = 8'd2;
    run(3);
    exp_fire = 1'b0;
    run(1);

    phase = "req_in_fire";
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    run(10);
    exp_fire = 1'b1; exp_cnt = 8'd3;
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    exp_fire = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    run(3);

    phase = "req_in_busy";
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    run(4);
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    run(8);

    phase = "wdt_saturate";
    for (int i = 0; i < 297; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      run(10);
      exp_fire = 1'b1;
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      run(3);
      exp_fire = 1'b0;
    end
    run(1);

    phase = "stretch_single";
    status = 8'h04; exp_led = 8'hFB;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    status = 8'h00;
    run(7);
    exp_led = 8'hFF;
    run(2);

    phase = "stretch_retrigger";
    status = 8'h04; exp_led = 8'hFB;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    status = 8'h00;
    run(4);
    status = 8'h04;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    status = 8'h00;
    run(7);
    exp_led = 8'hFF;
    run(2);

    phase = "stretch_held";
    status = 8'h81; exp_led = 8'h7E;
    run(3);
    status = 8'h00;
    run(7);
    exp_led = 8'hFF;
    run(2);

    phase = "async_reset";
    status = 8'h04; exp_led = 8'hFB;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    status = 8'h00;
    exp_led = 8'hFF; exp_to = 1'b0; exp_cnt = 8'd0;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);

    @(negedge clock);
    #1;
    phase = "drain";
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilotof_status_ctrl.md
Name: hilotof_status_ctrl

Overview:
Parametrised board-level housekeeping block for HiLoTOF tops. Generates the power-on system reset, combines host-requested and watchdog-forced DUT resets, and stretches single-cycle status pulses so they are visible on LEDs. Also drives a heartbeat and a watchdog that recovers a hung DUT. It sits between the top-level pins, hilotof_io and the dut instance.

Parameters:
RESET_CYCLES, 63, cycles sys_reset stays high after reset deasserts (must be ≥1)
N_CH, 8, number of status inputs / LED outputs
STRETCH_BITS, 20, status pulse stretched to 2^STRETCH_BITS cycles (must be ≥1)
HB_BITS, 26, heartbeat counter width; heartbeat = counter MSB
WDT_CYCLES, 1000000, max cycles from txn_start to txn_done; 0 disables watchdog
WDT_RST_CYCLES, 16, width of watchdog-forced dut_reset pulse (must be ≥1)
LED_ACTIVE_LOW, 1, 1 = led outputs inverted

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
sys_reset  out  1  stretched system reset for hilotof_io
dut_reset_req  in  1  DUT reset request from hilotof_io
dut_reset  out  1  reset to dut
txn_start  in  1  DUT input accepted (din_valid)
txn_done  in  1  DUT output accepted (dout_valid & dout_ready)
status  in  N_CH  raw status bits, bit i drives led[i]
wdt_timeout  out  1  sticky timeout flag
wdt_count  out  8  saturating timeout count
heartbeat  out  1  heartbeat blink
led  out  N_CH  stretched, polarity-adjusted status

Behaviour:
- reset asserted: all registers cleared asynchronously. Outputs during reset: sys_reset=1, dut_reset=1, wdt_timeout=0, wdt_count=0, heartbeat=0, led = all-off level (all 1s if LED_ACTIVE_LOW, else all 0s).
- Reset counter: width clog2(RESET_CYCLES+1). Increments each cycle while below RESET_CYCLES. sys_reset = (count != RESET_CYCLES), registered. After reset falls, sys_reset falls on exactly the RESET_CYCLES-th rising clock edge. The counter never re-arms without reset.
- dut_reset = sys_reset | dut_reset_req | wdt_fire. Combinational OR of registered terms; no added latency on dut_reset_req.
- Watchdog FSM, states IDLE, BUSY, FIRE. Held in IDLE while sys_reset=1 or dut_reset_req=1.
  - IDLE: on txn_start, load timer=0 and go to BUSY.
  - BUSY: timer increments each cycle.
    - txn_done → IDLE. txn_done takes priority over timeout in the same cycle.
    - txn_start and txn_done in the same cycle → stay BUSY, timer reset to 0 (back-to-back transaction).
    - timer reaches WDT_CYCLES-1 with no txn_done → FIRE: set wdt_timeout, wdt_count += 1 (saturates at 255), load pulse counter.
  - FIRE: wdt_fire=1 for exactly WDT_RST_CYCLES cycles, then IDLE. txn_start and txn_done are ignored while in FIRE.
  - dut_reset_req asserted mid-BUSY or mid-FIRE → IDLE immediately; wdt_fire drops on the next edge.
- WDT_CYCLES=0: FSM is tied to IDLE and wdt_fire=0 permanently.
- wdt_timeout and wdt_count are cleared only by reset. They are not cleared by sys_reset phase end or dut_reset_req.
- Stretcher, per channel: STRETCH_BITS-bit down-counter.
  - status[i]=1: load all-ones.
  - status[i]=0: decrement if nonzero.
  - lit[i] = status[i] | (cnt != 0).
  - Result: a 1-cycle pulse lights the channel for 2^STRETCH_BITS cycles total; a new pulse during stretch re-extends it.
- Heartbeat: HB_BITS free-running counter, wraps; heartbeat = MSB.
- led = lit XOR {N_CH{LED_ACTIVE_LOW}}, registered, 1 cycle after lit.

Test Plan:
- RESET_CYCLES=4: release reset at edge 0 → sys_reset=1 through edge 3, 0 from edge 4; dut_reset follows; asserting reset mid-count → sys_reset=1 asynchronously and the full 4-cycle count restarts.
- WDT_CYCLES=10, WDT_RST_CYCLES=3: txn_start, no done → wdt_timeout=1, wdt_count=1, dut_reset high for exactly 3 cycles starting 10 cycles after txn_start; txn_done at cycle 9 → no fire.
- Same params: txn_start and txn_done together at cycle 8 → no fire at 10; fire 10 cycles after cycle 8 if no further done. Force 300 timeouts → wdt_count saturates at 255.
- dut_reset_req pulse during FIRE and during BUSY → FSM returns to IDLE, wdt_fire ends next edge, wdt_timeout remains 1; WDT_CYCLES=0 with hung transaction → dut_reset never pulses.
- STRETCH_BITS=3, LED_ACTIVE_LOW=1: 1-cycle pulse on status[2] → led[2]=0 for exactly 8 cycles after 1-cycle latency; second pulse at cycle 5 → on 8 cycles from cycle 5; other leds stay 1.
- HB_BITS=3: heartbeat toggles every 4 cycles after reset, first high at cycle 4.
